// File: rtl/preset_chan_bank.sv
// preset_chan_bank: bank of CHANNELS configuration words, each WIDTH bits.
// Every word powers up and resets to its own constant from INIT_VALUES.
// Words change only through one valid/ready command port. The supported
// commands are load, add, restore one channel, and a sequenced restore-all
// sweep. All outputs come straight from registers, so no input reaches an
// output without passing through a flop.
module preset_chan_bank #(
    parameter int                          WIDTH       = 32,
    parameter int                          CHANNELS    = 3,
    parameter int                          CHW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter logic [CHANNELS*WIDTH-1:0]   INIT_VALUES = {32'd77, 32'd66, 32'd42}
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        wr_valid_i,
    output logic                        wr_ready_o,
    input  logic [1:0]                  wr_op_i,
    input  logic [CHW-1:0]              wr_chan_i,
    input  logic [WIDTH-1:0]            wr_data_i,
    output logic [CHANNELS*WIDTH-1:0]   data_o,
    output logic                        done_o,
    output logic                        err_o
);

    localparam logic [1:0]     OP_LOAD  = 2'b00;
    localparam logic [1:0]     OP_ADD   = 2'b01;
    localparam logic [1:0]     OP_ALL   = 2'b11;
    localparam logic [CHW-1:0] LAST_IDX = CHW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    // Declaration initialisers give defined outputs from time zero, even
    // before any reset has been applied.
    state_t                      state_q = IDLE;
    state_t                      state_d;
    logic [1:0]                  op_q    = 2'b00;
    logic [1:0]                  op_d;
    logic [CHW-1:0]              chan_q  = '0;
    logic [CHW-1:0]              chan_d;
    logic [WIDTH-1:0]            wdata_q = '0;
    logic [WIDTH-1:0]            wdata_d;
    logic [CHW-1:0]              idx_q   = '0;
    logic [CHW-1:0]              idx_d;
    logic [CHANNELS*WIDTH-1:0]   data_q  = INIT_VALUES;
    logic [CHANNELS*WIDTH-1:0]   data_d;
    logic                        ready_q = 1'b1;
    logic                        ready_d;
    logic                        done_q  = 1'b0;
    logic                        done_d;
    logic                        err_q   = 1'b0;
    logic                        err_d;
    logic                        chan_ok;

    function automatic logic [WIDTH-1:0] init_slice(input int i);
        return INIT_VALUES[i*WIDTH +: WIDTH];
    endfunction

    // Flag whether the latched channel index names a channel that exists.
    // The index can exceed CHANNELS-1 when CHANNELS is not a power of two.
    always_comb begin
        chan_ok = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (CHW'(i) == chan_q) chan_ok = 1'b1;
        end
    end

    // Next state: command acceptance, single-edge execution, restore-all sweep.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        chan_d  = chan_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        data_d  = data_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_valid_i && ready_q) begin
                    op_d    = wr_op_i;
                    chan_d  = wr_chan_i;
                    wdata_d = wr_data_i;
                    idx_d   = '0;
                    ready_d = 1'b0;
                    state_d = (wr_op_i == OP_ALL) ? SWEEP : EXEC;
                end
            end
            EXEC: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (CHW'(i) == chan_q) begin
                        if (op_q == OP_LOAD)
                            data_d[i*WIDTH +: WIDTH] = wdata_q;
                        else if (op_q == OP_ADD)
                            data_d[i*WIDTH +: WIDTH] = data_q[i*WIDTH +: WIDTH] + wdata_q;
                        else
                            data_d[i*WIDTH +: WIDTH] = init_slice(i);
                    end
                end
                done_d  = 1'b1;
                err_d   = ~chan_ok;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            SWEEP: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (CHW'(i) == idx_q) data_d[i*WIDTH +: WIDTH] = init_slice(i);
                end
                idx_d = idx_q + CHW'(1);
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and bank registers. Reset discards any in-flight command.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
            chan_q  <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            data_q  <= INIT_VALUES;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            chan_q  <= chan_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign wr_ready_o = ready_q;
    assign data_o     = data_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_preset_chan_bank.sv
// Scoreboard bench for preset_chan_bank. It keeps a reference model of the
// three channels. Each command pushes its expected bank image and error flag
// onto a queue. That entry is popped and compared when the DUT pulses done.
module tb_preset_chan_bank;

    localparam int WIDTH    = 32;
    localparam int CHANNELS = 3;
    localparam int CHW      = 2;

    logic                      clk_i = 1'b0;
    logic                      rst_ni = 1'b1;
    logic                      wr_valid_i = 1'b0;
    logic                      wr_ready_o;
    logic [1:0]                wr_op_i = 2'b00;
    logic [CHW-1:0]            wr_chan_i = '0;
    logic [WIDTH-1:0]          wr_data_i = '0;
    logic [CHANNELS*WIDTH-1:0] data_o;
    logic                      done_o;
    logic                      err_o;

    typedef struct {
        logic [95:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [3];
    logic [31:0] init_v [3];
    int          n_cmp = 0;
    int          n_bad = 0;

    preset_chan_bank #(
        .WIDTH      (WIDTH),
        .CHANNELS   (CHANNELS),
        .CHW        (CHW),
        .INIT_VALUES({32'd77, 32'd66, 32'd42})
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_valid_i(wr_valid_i),
        .wr_ready_o(wr_ready_o),
        .wr_op_i   (wr_op_i),
        .wr_chan_i (wr_chan_i),
        .wr_data_i (wr_data_i),
        .data_o    (data_o),
        .done_o    (done_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] pack3(input logic [31:0] c0, input logic [31:0] c1,
                                          input logic [31:0] c2);
        return {c2, c1, c0};
    endfunction

    // Drive one command, wait for its done pulse, and score the result.
    task automatic send(input logic [1:0] op, input logic [1:0] ch, input logic [31:0] d);
        exp_t        e;
        exp_t        got_e;
        logic [31:0] pre [3];
        logic [31:0] part [3];
        int          cyc;
        for (int k = 0; k < 3; k++) pre[k] = model[k];
        e.err = 1'b0;
        e.lat = (op == 2'b11) ? 3 : 1;
        if (op == 2'b11) begin
            for (int k = 0; k < 3; k++) model[k] = init_v[k];
        end else if (ch >= 2'd3) begin
            e.err = 1'b1;
        end else if (op == 2'b00) begin
            model[ch] = d;
        end else if (op == 2'b01) begin
            model[ch] = model[ch] + d;
        end else begin
            model[ch] = init_v[ch];
        end
        e.data = pack3(model[0], model[1], model[2]);
        sb.push_back(e);

        @(negedge clk_i);
        wr_valid_i = 1'b1;
        wr_op_i    = op;
        wr_chan_i  = ch;
        wr_data_i  = d;
        cyc = 0;
        while (!wr_ready_o && cyc < 20) begin
            @(negedge clk_i);
            cyc++;
        end
        @(posedge clk_i);
        #1;
        wr_valid_i = 1'b0;
        chk("ready_low_after_accept", {95'd0, wr_ready_o}, 96'd0);

        cyc = 0;
        while (!done_o && cyc < 20) begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (op == 2'b11 && !done_o && cyc < 3) begin
                for (int k = 0; k < 3; k++) part[k] = (k < cyc) ? init_v[k] : pre[k];
                chk("sweep_partial", data_o, pack3(part[0], part[1], part[2]));
            end
        end
        got_e = sb.pop_front();
        if (!done_o) begin
            chk("done_timeout", 96'd0, 96'd1);
        end else begin
            chk("latency", 96'(cyc), 96'(got_e.lat));
            chk("data", data_o, got_e.data);
            chk("err", {95'd0, err_o}, {95'd0, got_e.err});
            chk("ready_at_done", {95'd0, wr_ready_o}, 96'd1);
            @(posedge clk_i);
            #1;
            chk("done_single", {95'd0, done_o}, 96'd0);
            chk("err_single", {95'd0, err_o}, 96'd0);
        end
    endtask

    initial begin
        init_v[0] = 32'd42;
        init_v[1] = 32'd66;
        init_v[2] = 32'd77;
        for (int k = 0; k < 3; k++) model[k] = init_v[k];

        // Power-up values, no reset applied.
        #1;
        chk("pwr_data", data_o, pack3(32'd42, 32'd66, 32'd77));
        chk("pwr_ready", {95'd0, wr_ready_o}, 96'd1);
        chk("pwr_done", {95'd0, done_o}, 96'd0);
        chk("pwr_err", {95'd0, err_o}, 96'd0);

        send(2'b00, 2'd1, 32'd1234);
        send(2'b00, 2'd0, 32'hFFFF_FFF0);
        send(2'b01, 2'd0, 32'h0000_0020);
        send(2'b01, 2'd2, 32'd5);

        for (int k = 0; k < 3; k++) send(2'b00, 2'(k), 32'd0);
        send(2'b11, 2'd0, 32'd0);

        send(2'b00, 2'd3, 32'hDEAD_BEEF);
        send(2'b00, 2'd1, 32'd9);
        send(2'b10, 2'd1, 32'd0);

        // Restore-all interrupted by an asynchronous reset between edges.
        for (int k = 0; k < 3; k++) send(2'b00, 2'(k), 32'd0);
        @(negedge clk_i);
        wr_valid_i = 1'b1;
        wr_op_i    = 2'b11;
        @(posedge clk_i);
        #1;
        wr_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("midsweep_ch0", data_o, pack3(32'd42, 32'd0, 32'd0));
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_data", data_o, pack3(32'd42, 32'd66, 32'd77));
        chk("rst_ready", {95'd0, wr_ready_o}, 96'd1);
        chk("rst_done", {95'd0, done_o}, 96'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) model[k] = init_v[k];
        send(2'b00, 2'd2, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/preset_chan_bank.md
# preset_chan_bank

Multi-channel bank of WIDTH-bit output registers, each with a per-channel power-up/reset value fixed by parameter. Channels are modified through a single valid/ready command port: load, add, restore one channel, or a sequenced restore-all sweep. Outputs hold defined values from time zero, before any reset is applied. The bank supplies constant-until-written configuration words to downstream blocks; each channel replaces a standalone `output reg` with an initialiser.

## Interface
- WIDTH, 32, bits per channel
- CHANNELS, 3, number of channels (>=1)
- CHW, $clog2(CHANNELS) min 1, channel index width
- INIT_VALUES, {32'd77, 32'd66, 32'd42}, packed CHANNELS*WIDTH init vector; channel i at bits [i*WIDTH +: WIDTH]

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_valid  in  1  command present
- wr_ready  out  1  bank can accept a command
- wr_op  in  2  00 load, 01 add, 10 restore channel, 11 restore all
- wr_chan  in  CHW  target channel; ignored for op 11
- wr_data  in  WIDTH  operand for ops 00/01
- data  out  CHANNELS*WIDTH  channel values, packed as INIT_VALUES
- done  out  1  one-cycle pulse, command finished
- err  out  1  one-cycle pulse with done, command targeted a nonexistent channel

## Operation
- All outputs are regs with declaration initialisers equal to their reset values, so they are valid at time 0 without reset: data=INIT_VALUES, wr_ready=1, done=0, err=0, state IDLE.
- rst_n low: immediately, independent of clk, data=INIT_VALUES, wr_ready=1, done=0, err=0, state IDLE, sweep index 0. Any in-flight command is discarded.
- States: IDLE, EXEC, SWEEP.
- IDLE: accept on the rising edge with wr_valid && wr_ready. Latch op, chan, data; set wr_ready=0. Ops 00/01/10 go to EXEC. Op 11 goes to SWEEP with index 0.
- EXEC, one edge:
  - op 00: channel = wr_data.
  - op 01: channel = (channel + wr_data) mod 2^WIDTH; carry discarded.
  - op 10: channel = its INIT slice.
  - Then done=1, wr_ready=1, back to IDLE.
  - If latched chan >= CHANNELS: no channel changes, done=1 and err=1.
- SWEEP: each edge restores channel[index] to its INIT slice and increments index. The edge that restores channel CHANNELS-1 also sets done=1 and wr_ready=1 and returns to IDLE. err stays 0.
- Only the addressed channel changes; all other channels hold.
- wr_valid while wr_ready=0 is ignored. The master must hold the command until it sees ready.

## Timing
- Accept at edge N. Ops 00/01/10 update data at edge N+1, with done high for cycle N+1..N+2. wr_ready returns high after N+1, so the next accept is possible at N+2 at the earliest.
- Op 11: channel k restored at edge N+1+k. done is high after edge N+CHANNELS, and wr_ready=0 for CHANNELS cycles.
- done and err are registered and are never high for more than one cycle.
- Reset deasserting at any point leaves the bank in IDLE with wr_ready=1. The first accept can occur at the first edge after rst_n rises.
- No combinational path from inputs to outputs.

## Test plan
- Power-up, no reset applied, sample at #1 -> channel0=42, channel1=66, channel2=77, wr_ready=1, done=0, err=0.
- Load op 00, chan 1, data 1234 -> wr_ready low one cycle; channel1=1234 after the next edge with a single done pulse; channels 0 and 2 stay 42 and 77.
- Load chan 0 with 0xFFFFFFF0, then add op 01 with 0x20 -> channel0=0x00000010, no err. Add 5 to channel2 -> 82.
- After loading all channels to 0, restore-all op 11 -> channels become 42, 66, 77 on successive edges in order 0,1,2; wr_ready low exactly 3 cycles; one done pulse with err=0.
- Op 00 with chan 3 (CHANNELS=3) -> done and err pulse together; data unchanged. Op 10 on chan 1 after loading 9 -> channel1=66.
- Assert rst_n low mid-sweep, between clock edges -> data=INIT_VALUES and wr_ready=1 before the next edge. After release, a load of chan 2 = 5 completes normally.
